hdr_loader: RTL

- Upstream feeder for proc. Fetches one packet header from packet memory over the shared mem interface as 32-bit word reads.
- Assembles the bytes into the HDR_MAX_LEN-byte header array, zero-pads the tail, then pulses proc's start once proc reports ready.
- Holds the assembled header stable until the next load is accepted, so proc can sample pkt_hdr_o at any time after the start pulse.

---
 rtl/hdr_loader.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/hdr_loader.sv
// hdr_loader: fetches one packet header from packet memory as 32-bit word
// reads, assembles it big-endian into a HDR_MAX_LEN-byte array, zero-pads the
// tail and pulses pkt_start_o to proc once proc_ready_i is high. The header
// stays stable until the next accepted load.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   load_i          one-cycle load request, accepted only while busy_o=0
//   base_addr_i     byte address of header byte 0
//   len_i           header length in bytes (0..HDR_MAX_LEN)
//   busy_o          high from the accepting edge through the pkt_start_o cycle
//   mem_ce_o/we_o/addr_o/width_o, mem_data_i   shared memory read port
//   proc_ready_i    proc ready; pkt_start_o one-cycle start pulse to proc
//   pkt_hdr_o       header bytes, index 0 first
//   err_o           bad-load flag (only meaningful with the macro below)
//
// Macro HDR_LOADER_CHECK_EN: when defined, a load with a misaligned base or
// len_i > HDR_MAX_LEN raises err_o and performs no reads. When undefined the
// low address bits are ignored, len_i is clamped and err_o stays 0.
`timescale 1ns/1ps

module hdr_loader #(
    parameter int HDR_MAX_LEN = 64,
    parameter int MEM_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_i,
    input  logic [31:0]                  base_addr_i,
    input  logic [6:0]                   len_i,
    output logic                         busy_o,
    output logic                         mem_ce_o,
    output logic                         mem_we_o,
    output logic [31:0]                  mem_addr_o,
    output logic [3:0]                   mem_width_o,
    input  logic [31:0]                  mem_data_i,
    input  logic                         proc_ready_i,
    output logic                         pkt_start_o,
    output logic [HDR_MAX_LEN-1:0][7:0]  pkt_hdr_o,
    output logic                         err_o
);
    localparam int NWORDS = HDR_MAX_LEN / 4;
    localparam int IW     = 6;
    localparam int PW     = MEM_LATENCY * IW;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_WAIT, S_ERR} state_t;

    state_t                            state;
    logic [6:0]                        hdr_len;
    logic [IW-1:0]                     nwords;
    logic [IW-1:0]                     cur_idx;   // word index of the request now on the bus
    logic [MEM_LATENCY-1:0]            vld_pipe;  // requests in flight, [MEM_LATENCY-1] returns now
    logic [MEM_LATENCY-1:0][IW-1:0]    idx_pipe;

    logic                              bad_load;
    logic [31:0]                       base_eff;
    logic [6:0]                        len_eff;
    logic [IW-1:0]                     nwords_in;
    logic [MEM_LATENCY-1:0]            vld_early;
    logic                              drain_done;

    assign mem_we_o    = 1'b0;
    assign mem_width_o = 4'd4;
    // Combinational so the pulse lands in the very first ready cycle.
    assign pkt_start_o = (state == S_WAIT) && proc_ready_i;

    always_comb begin
        bad_load = 1'b0;
`ifdef HDR_LOADER_CHECK_EN
        bad_load = (base_addr_i[1:0] != 2'b00) || (32'(len_i) > HDR_MAX_LEN);
`endif
        base_eff  = base_addr_i & 32'hFFFF_FFFC;
        len_eff   = (32'(len_i) > HDR_MAX_LEN) ? 7'(HDR_MAX_LEN) : len_i;
        nwords_in = IW'(({1'b0, len_eff} + 8'd3) >> 2);
    end

    // DRAIN may leave as soon as only the returning stage is occupied: that
    // word is captured on the same edge, so WAIT already sees the full header.
    assign vld_early  = vld_pipe << 1;
    assign drain_done = (vld_early == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            busy_o     <= 1'b0;
            mem_ce_o   <= 1'b0;
            mem_addr_o <= '0;
            err_o      <= 1'b0;
            pkt_hdr_o  <= '0;
            hdr_len    <= '0;
            nwords     <= '0;
            cur_idx    <= '0;
            vld_pipe   <= '0;
            idx_pipe   <= '0;
        end else begin
            vld_pipe <= MEM_LATENCY'({vld_pipe, mem_ce_o});
            idx_pipe <= PW'({idx_pipe, cur_idx});

            // Returning word: big-endian, bytes at or beyond hdr_len zeroed.
            if (vld_pipe[MEM_LATENCY-1]) begin
                for (int w = 0; w < NWORDS; w++) begin
                    if (idx_pipe[MEM_LATENCY-1] == IW'(w)) begin
                        for (int b = 0; b < 4; b++) begin
                            pkt_hdr_o[4*w+b] <= (4*w + b < int'(hdr_len)) ?
                                                mem_data_i[31-8*b -: 8] : 8'h00;
                        end
                    end
                end
            end

            case (state)
                S_IDLE: begin
                    if (load_i) begin
                        busy_o     <= 1'b1;
                        err_o      <= bad_load;
                        pkt_hdr_o  <= '0;
                        hdr_len    <= len_eff;
                        nwords     <= nwords_in;
                        mem_addr_o <= base_eff;
                        cur_idx    <= '0;
                        if (bad_load) begin
                            state <= S_ERR;
                        end else if (nwords_in == '0) begin
                            state <= S_WAIT;
                        end else begin
                            mem_ce_o <= 1'b1;
                            state    <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (cur_idx + IW'(1) < nwords) begin
                        cur_idx    <= cur_idx + IW'(1);
                        mem_addr_o <= mem_addr_o + 32'd4;
                    end else begin
                        mem_ce_o <= 1'b0;
                        state    <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drain_done) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (proc_ready_i) begin
                        busy_o <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                S_ERR: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
